// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for common-anode 7-segment digits on a shared segment bus.
// New display values are double-buffered and committed only at frame boundaries.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  typedef enum logic {S_EMPTY, S_FULL} pend_state_e;

  pend_state_e           state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      active, pending;
  logic                  tick_c, boundary_c, accept_c, commit_c, in_blank_c;
  logic [3:0]            nibble_c;
  logic                  mask_bit_c;
  logic [NUM_DIGITS-1:0] dig_nxt_c;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick_c     = en && (cnt == CNT_LAST);
  assign boundary_c = tick_c && (idx == IDX_LAST);
  assign dig_nxt_c  = ~(NUM_DIGITS'(1) << idx);

  // Leading part of every slot with all digits off to hide ghosting
  if (BLANK_CYCLES > 0) begin : g_blank
    assign in_blank_c = cnt < CNT_W'(BLANK_CYCLES);
  end else begin : g_no_blank
    assign in_blank_c = 1'b0;
  end

  // Select the active nibble and live mask bit for the current slot
  always_comb begin
    nibble_c   = 4'h0;
    mask_bit_c = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx == IDX_W'(k)) begin
        nibble_c   = active[4*k +: 4];
        mask_bit_c = blank_mask[k];
      end
    end
  end

  // Pending-buffer FSM: fill on handshake, drain into active at a frame boundary
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    commit_c  = 1'b0;
    case (state)
      S_EMPTY: begin
        if (wr_valid) begin
          accept_c  = 1'b1;
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (boundary_c) begin
          commit_c  = 1'b1;
          state_nxt = S_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      wr_ready   <= 1'b1;
      seg        <= SEG_OFF;
      dig_sel    <= '1;
      frame_done <= 1'b0;
    end else begin
      wr_ready   <= (state_nxt == S_EMPTY);
      frame_done <= boundary_c;
      if (accept_c) pending <= wr_value;
      if (commit_c) active  <= pending;

      if (en) begin
        cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        if (tick_c) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end

      if (!en || in_blank_c) begin
        seg     <= SEG_OFF;
        dig_sel <= '1;
      end else begin
        seg     <= mask_bit_c ? SEG_OFF : hex_decode(nibble_c);
        dig_sel <= dig_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: per-cycle scoreboard against a reference model,
// a decode vector table, and directed multi-cycle sequences.
module tb_hex_display_scanner;

  localparam int unsigned N = 4;
  localparam int unsigned P = 4;
  localparam int unsigned B = 1;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       rdy;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [15:0]  wr_value = 16'h0;
  logic [3:0]   blank_mask = 4'h0;
  logic [6:0]   seg;
  logic [3:0]   dig_sel;
  logic         frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  vec_t vecs [16];

  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_value(wr_value), .blank_mask(blank_mask), .seg(seg), .dig_sel(dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: on each edge push the outputs the DUT must show after it
  int         m_cnt, m_idx;
  bit         m_full;
  logic [15:0] m_act, m_pend;
  exp_t       q[$];

  always @(posedge clk) begin
    exp_t e;
    bit   tick, bnd;
    if (reset) begin
      e = '{7'h7F, 4'hF, 1'b1, 1'b0};
      m_cnt = 0; m_idx = 0; m_full = 0; m_act = '0;
    end else begin
      tick = en && (m_cnt == P - 1);
      bnd  = tick && (m_idx == N - 1);
      if (!en || m_cnt < B) begin
        e.seg = 7'h7F;
        e.dig = 4'hF;
      end else begin
        e.dig = 4'hF ^ (4'h1 << m_idx);
        e.seg = blank_mask[m_idx] ? 7'h7F : vecs[m_act[4*m_idx +: 4]].seg;
      end
      e.fd = bnd;
      if (m_full) begin
        if (bnd) begin m_act = m_pend; m_full = 0; end
      end else if (wr_valid) begin
        m_pend = wr_value; m_full = 1;
      end
      e.rdy = !m_full;
      if (en) begin
        if (tick) begin m_cnt = 0; m_idx = (m_idx + 1) % N; end
        else m_cnt++;
      end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if ({seg, dig_sel, wr_ready, frame_done} !== {e.seg, e.dig, e.rdy, e.fd}) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got seg=%h dig=%b rdy=%b fd=%b, expected seg=%h dig=%b rdy=%b fd=%b",
                 $time, seg, dig_sel, wr_ready, frame_done, e.seg, e.dig, e.rdy, e.fd);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_fd();
    int k = 0;
    while (frame_done !== 1'b1 && k < 64) begin step(1); k++; end
    if (k >= 64) timeout("wait_frame_done");
  endtask

  task automatic wait_dig(input logic [3:0] d);
    int k = 0;
    while (dig_sel !== d && k < 64) begin step(1); k++; end
    if (k >= 64) timeout("wait_dig_sel");
  endtask

  task automatic offer_hs(input logic [15:0] v);
    int k = 0;
    wr_value = v;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && k < 64) begin step(1); k++; end
    if (k >= 64) timeout("wait_wr_ready");
    step(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    for (int i = 0; i < 16; i++) begin
      vecs[i].nib = 4'(i);
      vecs[i].seg = segtab[i];
    end

    // Reset values
    step(3);
    check("reset_seg", 16'(seg), 16'h7F);
    check("reset_dig_sel", 16'(dig_sel), 16'hF);
    check("reset_wr_ready", 16'(wr_ready), 16'h1);
    check("reset_frame_done", 16'(frame_done), 16'h0);
    reset = 1'b0;

    // Free-running scan: two frame pulses in 32 cycles
    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (frame_done === 1'b1) fd_cnt++;
    end
    check("frame_done_rate", 16'(fd_cnt), 16'd2);

    // Mid-frame write, ignored second offer while busy
    wait_fd();
    step(5);
    wr_value = 16'h1234; wr_valid = 1'b1;
    step(1);
    check("busy_after_accept", 16'(wr_ready), 16'h0);
    wr_value = 16'hABCD;
    step(1);
    wr_valid = 1'b0;
    wait_fd();
    check("ready_after_commit", 16'(wr_ready), 16'h1);
    wait_dig(4'b1110);
    check("digit0_is_4", 16'(seg), 16'h19);
    wait_dig(4'b0111);
    check("digit3_is_1", 16'(seg), 16'h79);

    // Re-offer with handshake
    offer_hs(16'hABCD);
    wait_fd();
    wait_dig(4'b1110);
    check("digit0_is_D", 16'(seg), 16'h21);

    // Acceptance on the exact boundary edge commits one frame later
    wait_fd();
    step(15);
    wr_value = 16'h9876; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    check("boundary_accept_fd", 16'(frame_done), 16'h1);
    check("boundary_accept_busy", 16'(wr_ready), 16'h0);
    wait_dig(4'b1110);
    check("no_bypass_digit0", 16'(seg), 16'h21);
    wait_fd();
    wait_dig(4'b1110);
    check("late_commit_digit0", 16'(seg), 16'h02);

    // Live blank mask on digit1
    blank_mask = 4'b0010;
    wait_dig(4'b1101);
    check("masked_digit1", 16'(seg), 16'h7F);
    wait_dig(4'b1011);
    check("unmasked_digit2", 16'(seg), 16'h00);
    blank_mask = 4'b0000;

    // Scan freeze for 5 cycles mid-slot
    wait_fd();
    step(5);
    en = 1'b0;
    step(1);
    check("freeze_seg", 16'(seg), 16'h7F);
    check("freeze_dig", 16'(dig_sel), 16'hF);
    step(4);
    en = 1'b1;
    step(1);
    check("resume_dig", 16'(dig_sel), 16'hD);
    check("resume_seg", 16'(seg), 16'h78);

    // Reset discards a pending value
    offer_hs(16'h1111);
    check("pending_busy", 16'(wr_ready), 16'h0);
    reset = 1'b1;
    step(1);
    check("rst_ready", 16'(wr_ready), 16'h1);
    check("rst_seg", 16'(seg), 16'h7F);
    reset = 1'b0;
    wait_fd();
    wait_dig(4'b1110);
    check("post_rst_digit0", 16'(seg), 16'h40);
    wait_dig(4'b0111);
    check("post_rst_digit3", 16'(seg), 16'h40);

    // Decode table sweep
    for (int i = 0; i < 16; i++) begin
      offer_hs({4{vecs[i].nib}});
      wait_fd();
      step(1);
      wait_fd();
      wait_dig(4'b1011);
      check($sformatf("decode_%h", vecs[i].nib), 16'(seg), 16'(vecs[i].seg));
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
